orb_bank_writer: RTL

Fills the inactive half of the ping-pong orbit memory that the M16-style serializer reads. Up to NCH source channels request word writes. A round-robin arbiter shares the single memory write port between them. Each channel owns a fixed region of the bank, and all regions are re-armed every time the serializer swaps banks.

---
 rtl/orb_bank_writer_if.sv | 50 +++++
 rtl/orb_bank_writer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/orb_bank_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : orb_bank_writer_if
// Description : Request/ack channel bundle and memory write bus of the orbit
//               bank writer.
// Revision    : 1.0
// ============================================================================
interface orb_bank_writer_if #(
    parameter int NCH = 4
);
    logic                 iSwitch;
    logic [NCH-1:0]       iReq;
    logic [12*NCH-1:0]    iData;
    logic [NCH-1:0]       oAck;
    logic [11:0]          oWrAddr;
    logic [11:0]          oWrData;
    logic                 oWrEn;
    logic                 oFillDone;
    logic [NCH-1:0]       oUnderrun;
    logic [7:0]           oSwapCnt;

    // Source side: sources and the serializer drive requests and the bank select.
    modport master (
        output iSwitch,
        output iReq,
        output iData,
        input  oAck,
        input  oWrAddr,
        input  oWrData,
        input  oWrEn,
        input  oFillDone,
        input  oUnderrun,
        input  oSwapCnt
    );

    // Writer side.
    modport slave (
        input  iSwitch,
        input  iReq,
        input  iData,
        output oAck,
        output oWrAddr,
        output oWrData,
        output oWrEn,
        output oFillDone,
        output oUnderrun,
        output oSwapCnt
    );
endinterface
`default_nettype wire

// File: rtl/orb_bank_writer.sv
`default_nettype none
// ============================================================================
// Module      : orb_bank_writer
// Description : Round-robin arbiter filling the inactive half of the ping-pong
//               orbit memory, one fixed region per channel, re-armed per swap.
// Revision    : 1.0
// ============================================================================
module orb_bank_writer #(
    parameter int NCH   = 4,
    parameter int CH_W  = 2,
    parameter int QUOTA = 512,
    parameter int Q_W   = 9
) (
    input  wire logic         iClkOrb,
    input  wire logic         reset,
    orb_bank_writer_if.slave  bus
);

    localparam logic [Q_W:0] c_quota = (Q_W+1)'(QUOTA);
    localparam logic [Q_W:0] c_one   = (Q_W+1)'(1);

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_stateNxt;

    logic               r_swQ;
    logic               r_swapPend;
    logic [CH_W-1:0]    r_last;
    logic [CH_W-1:0]    r_ch;
    logic [Q_W:0]       r_cnt [NCH];

    logic [NCH-1:0]     r_ack;
    logic [11:0]        r_wrAddr;
    logic [11:0]        r_wrData;
    logic               r_wrEn;
    logic               r_fillDone;
    logic [NCH-1:0]     r_underrun;
    logic [7:0]         r_swapCnt;

    logic [NCH-1:0]     w_eligible;
    logic [11:0]        w_chData [NCH];
    logic               w_found;
    logic [CH_W-1:0]    w_winCh;
    logic [Q_W:0]       w_winCnt;
    logic [11:0]        w_grantAddr;
    logic               w_doSwap;
    logic               w_doGrant;
    logic               w_doWrite;
    logic               w_allFull;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            assign w_chData[gi]   = bus.iData[12*gi +: 12];
            assign w_eligible[gi] = bus.iReq[gi] && (r_cnt[gi] < c_quota);
        end
    endgenerate

    // Descending scan so the channel nearest after r_last is the final winner.
    always_comb begin
        w_found = 1'b0;
        w_winCh = '0;
        for (int k = NCH; k >= 1; k--) begin
            if (w_eligible[r_last + CH_W'(k)]) begin
                w_found = 1'b1;
                w_winCh = r_last + CH_W'(k);
            end
        end
    end

    assign w_winCnt    = r_cnt[w_winCh];
    assign w_grantAddr = {~r_swQ, w_winCh, w_winCnt[Q_W-1:0]};

    // Fill is complete when every region is full once the current write lands.
    always_comb begin
        w_allFull = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (CH_W'(i) == r_ch) begin
                if ((r_cnt[i] + c_one) != c_quota) begin
                    w_allFull = 1'b0;
                end
            end else if (r_cnt[i] != c_quota) begin
                w_allFull = 1'b0;
            end
        end
    end

    always_comb begin
        w_stateNxt = r_state;
        w_doSwap   = 1'b0;
        w_doGrant  = 1'b0;
        w_doWrite  = 1'b0;
        case (r_state)
            ST_ARB: begin
                if (r_swapPend) begin
                    w_doSwap = 1'b1;
                end else if (w_found) begin
                    w_doGrant  = 1'b1;
                    w_stateNxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_doWrite  = 1'b1;
                w_stateNxt = ST_ARB;
            end
            default: w_stateNxt = ST_ARB;
        endcase
    end

    always_ff @(posedge iClkOrb) begin
        if (!reset) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_stateNxt;
        end
    end

    always_ff @(posedge iClkOrb) begin
        if (!reset) begin
            r_swQ      <= bus.iSwitch;
            r_swapPend <= 1'b0;
            r_last     <= CH_W'(NCH-1);
            r_ch       <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i] <= '0;
            end
            r_ack      <= '0;
            r_wrAddr   <= '0;
            r_wrData   <= '0;
            r_wrEn     <= 1'b0;
            r_fillDone <= 1'b0;
            r_underrun <= '0;
            r_swapCnt  <= '0;
        end else begin
            r_wrEn <= 1'b0;
            r_ack  <= '0;

            if (w_doSwap) begin
                for (int i = 0; i < NCH; i++) begin
                    r_underrun[i] <= (r_cnt[i] != c_quota);
                    r_cnt[i]      <= '0;
                end
                r_fillDone <= 1'b0;
                r_swapCnt  <= r_swapCnt + 8'd1;
                r_swapPend <= 1'b0;
            end

            // A toggle seen this cycle outranks the clear above: it is a newer swap.
            if (bus.iSwitch != r_swQ) begin
                r_swQ      <= bus.iSwitch;
                r_swapPend <= 1'b1;
            end

            if (w_doGrant) begin
                r_wrAddr <= w_grantAddr;
                r_wrData <= w_chData[w_winCh];
                r_wrEn   <= 1'b1;
                r_ack    <= NCH'(1) << w_winCh;
                r_last   <= w_winCh;
                r_ch     <= w_winCh;
            end

            if (w_doWrite) begin
                r_cnt[r_ch] <= r_cnt[r_ch] + c_one;
                r_fillDone  <= w_allFull;
            end
        end
    end

    assign bus.oAck      = r_ack;
    assign bus.oWrAddr   = r_wrAddr;
    assign bus.oWrData   = r_wrData;
    assign bus.oWrEn     = r_wrEn;
    assign bus.oFillDone = r_fillDone;
    assign bus.oUnderrun = r_underrun;
    assign bus.oSwapCnt  = r_swapCnt;

endmodule
`default_nettype wire
